// File: rtl/mips_main_control.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback
// plus the R-type ALU decoder; outputs decode the state register, gated off during reset.
module mips_main_control (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  output logic [3:0] o_state,
  output logic       o_pc_en,
  output logic       o_iord,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_pc_src,
  output logic [2:0] o_alu_control,
  output logic       o_illegal_op
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] r_state;
  logic [3:0] w_cur;
  logic [3:0] w_next;
  logic       w_pc_write;
  logic       w_branch;
  logic       w_iord;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_pc_src;
  logic [2:0] w_alu_control;
  logic       w_illegal;

  // Reset presents FETCH on the outputs regardless of the register contents.
  assign w_cur = i_reset ? S_FETCH : r_state;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_FETCH;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next        = S_FETCH;
    w_pc_write    = 1'b0;
    w_branch      = 1'b0;
    w_iord        = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_dst     = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_reg_write   = 1'b0;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = 2'b00;
    w_pc_src      = 2'b00;
    w_alu_control = 3'b000;
    w_illegal     = 1'b0;
    case (w_cur)
      S_FETCH: begin
        w_next        = S_DECODE;
        w_alu_src_b   = 2'b01;
        w_alu_control = ALU_ADD;
        w_ir_write    = 1'b1;
        w_pc_write    = 1'b1;
      end
      S_DECODE: begin
        w_alu_src_b   = 2'b11;
        w_alu_control = ALU_ADD;
        case (i_op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_next        = (i_op == OP_SW) ? S_MEMWR : S_MEMRD;
        w_alu_src_a   = 1'b1;
        w_alu_src_b   = 2'b10;
        w_alu_control = ALU_ADD;
      end
      S_MEMRD: begin
        w_next = S_MEMWB;
        w_iord = 1'b1;
      end
      S_MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
      end
      S_MEMWR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECUTE: begin
        // Unknown funct still completes as an add so the writeback slot is not lost.
        w_next      = S_ALUWB;
        w_alu_src_a = 1'b1;
        case (i_funct)
          6'b100000: w_alu_control = ALU_ADD;
          6'b100010: w_alu_control = ALU_SUB;
          6'b100100: w_alu_control = ALU_AND;
          6'b100101: w_alu_control = ALU_OR;
          6'b101010: w_alu_control = ALU_SLT;
          default: begin
            w_alu_control = ALU_ADD;
            w_illegal     = 1'b1;
          end
        endcase
      end
      S_ALUWB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a   = 1'b1;
        w_alu_control = ALU_SUB;
        w_pc_src      = 2'b01;
        w_branch      = 1'b1;
      end
      S_ADDIEX: begin
        w_next        = S_ADDIWB;
        w_alu_src_a   = 1'b1;
        w_alu_src_b   = 2'b10;
        w_alu_control = ALU_ADD;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
      end
      S_JUMP: begin
        w_pc_src   = 2'b10;
        w_pc_write = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Write enables and the illegal pulse are suppressed while reset is held.
  assign o_state       = w_cur;
  assign o_pc_en       = ~i_reset & (w_pc_write | (w_branch & i_zero));
  assign o_iord        = w_iord;
  assign o_mem_write   = ~i_reset & w_mem_write;
  assign o_ir_write    = ~i_reset & w_ir_write;
  assign o_reg_dst     = w_reg_dst;
  assign o_mem_to_reg  = w_mem_to_reg;
  assign o_reg_write   = ~i_reset & w_reg_write;
  assign o_alu_src_a   = w_alu_src_a;
  assign o_alu_src_b   = w_alu_src_b;
  assign o_pc_src      = w_pc_src;
  assign o_alu_control = w_alu_control;
  assign o_illegal_op  = ~i_reset & w_illegal;

endmodule
